// File: rtl/tri_wire_sequencer.sv
// ---------------------------------------------------------------------------
// tri_wire_sequencer
//
// Purpose:
//   Turns one accepted triangle (three unsigned vertices) into three line
//   requests for an external line engine, in the order v0->v1, v1->v2, v2->v0.
//   Each request is a level handshake: draw_line_Start stays high until the
//   engine answers with draw_line_Done, then Start drops for exactly one
//   cycle so the engine can return to idle before the next edge.
//   A triangle whose three vertices coincide draws nothing and is counted
//   immediately. Completed and culled triangles are both counted.
//
// Ports:
//   Clk              - single clock, all state changes on the rising edge
//   Reset            - synchronous, active-high reset
//   tri_valid        - a triangle is presented on vx0..vy2
//   tri_ready        - sequencer is idle and takes a triangle this cycle
//   vx0..vy2         - vertex coordinates (COORD_W bits each, unsigned)
//   draw_line_Start  - level request to the line engine
//   draw_line_Done   - line engine completion, honoured only while waiting
//   x0, y0, x1, y1   - registered endpoints of the current edge
//   busy             - a triangle is in progress
//   tri_count        - triangles finished or culled since reset (wraps)
// ---------------------------------------------------------------------------
module tri_wire_sequencer #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [COORD_W-1:0] vx0,
  input  logic [COORD_W-1:0] vy0,
  input  logic [COORD_W-1:0] vx1,
  input  logic [COORD_W-1:0] vy1,
  input  logic [COORD_W-1:0] vx2,
  input  logic [COORD_W-1:0] vy2,
  output logic               draw_line_Start,
  input  logic               draw_line_Done,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic [CNT_W-1:0]   tri_count
);

  typedef enum logic [2:0] {
    IDLE,
    EDGE_START,
    EDGE_WAIT,
    EDGE_GAP,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  // Private copy of the accepted triangle; the input bus is free to change
  // as soon as the triangle has been taken.
  logic [COORD_W-1:0] px0, py0, px1, py1, px2, py2;

  logic [1:0] edge_idx;

  logic accept;
  logic degenerate;
  logic advance;
  logic load_edge;
  logic [1:0] load_idx;

  // Vertex source for the endpoint mux: live inputs on the acceptance cycle
  // (the private copy is only written at that same edge), private copy after.
  logic [COORD_W-1:0] sx0, sy0, sx1, sy1, sx2, sy2;
  logic [COORD_W-1:0] ep_x0, ep_y0, ep_x1, ep_y1;

  // Handshake and decision terms shared by the FSM and the datapath.
  assign accept     = tri_valid && tri_ready;
  assign degenerate = (vx0 == vx1) && (vx1 == vx2) && (vy0 == vy1) && (vy1 == vy2);
  assign advance    = (state == EDGE_GAP) && (edge_idx != 2'd2);
  assign load_edge  = (accept && !degenerate) || advance;
  assign load_idx   = accept ? 2'd0 : (edge_idx + 2'd1);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Done is only looked at in EDGE_WAIT, so a stray pulse
  // elsewhere can never skip an edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = degenerate ? FINISH : EDGE_START;
        end
      end
      EDGE_START: begin
        state_next = EDGE_WAIT;
      end
      EDGE_WAIT: begin
        if (draw_line_Done) begin
          state_next = EDGE_GAP;
        end
      end
      EDGE_GAP: begin
        state_next = (edge_idx == 2'd2) ? FINISH : EDGE_START;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs, decoded from the state alone so tri_ready has no
  // combinational path from tri_valid.
  always_comb begin
    tri_ready       = (state == IDLE);
    busy            = (state != IDLE);
    draw_line_Start = (state == EDGE_START) || (state == EDGE_WAIT);
  end

  // Capture the triangle on acceptance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      px0 <= '0;
      py0 <= '0;
      px1 <= '0;
      py1 <= '0;
      px2 <= '0;
      py2 <= '0;
    end else if (accept) begin
      px0 <= vx0;
      py0 <= vy0;
      px1 <= vx1;
      py1 <= vy1;
      px2 <= vx2;
      py2 <= vy2;
    end
  end

  // Edge index: restarts at every acceptance, steps once per gap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      edge_idx <= 2'd0;
    end else if (accept) begin
      edge_idx <= 2'd0;
    end else if (advance) begin
      edge_idx <= edge_idx + 2'd1;
    end
  end

  // Select which vertex set feeds the endpoint mux.
  always_comb begin
    if (accept) begin
      sx0 = vx0;
      sy0 = vy0;
      sx1 = vx1;
      sy1 = vy1;
      sx2 = vx2;
      sy2 = vy2;
    end else begin
      sx0 = px0;
      sy0 = py0;
      sx1 = px1;
      sy1 = py1;
      sx2 = px2;
      sy2 = py2;
    end
  end

  // Endpoints of the edge about to be issued; edge 2 closes the loop back
  // to vertex 0.
  always_comb begin
    ep_x0 = sx0;
    ep_y0 = sy0;
    ep_x1 = sx1;
    ep_y1 = sy1;
    case (load_idx)
      2'd1: begin
        ep_x0 = sx1;
        ep_y0 = sy1;
        ep_x1 = sx2;
        ep_y1 = sy2;
      end
      2'd2: begin
        ep_x0 = sx2;
        ep_y0 = sy2;
        ep_x1 = sx0;
        ep_y1 = sy0;
      end
      default: begin
        ep_x0 = sx0;
        ep_y0 = sy0;
        ep_x1 = sx1;
        ep_y1 = sy1;
      end
    endcase
  end

  // Endpoint registers are written only on the transition into EDGE_START,
  // so they hold still for the whole start/wait/gap window of each edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x0 <= '0;
      y0 <= '0;
      x1 <= '0;
      y1 <= '0;
    end else if (load_edge) begin
      x0 <= ep_x0;
      y0 <= ep_y0;
      x1 <= ep_x1;
      y1 <= ep_y1;
    end
  end

  // Triangle counter, bumped once per pass through FINISH; an aborted
  // triangle never reaches FINISH and so is never counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tri_count <= '0;
    end else if (state == FINISH) begin
      tri_count <= tri_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tri_wire_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tri_wire_sequencer
//
// Self-checking bench for tri_wire_sequencer. The bench plays the line
// engine: it answers each request after a chosen number of wait cycles and
// compares requests, endpoints, busy time and the triangle counter against
// a reference derived from the vertex list. The counter is narrowed to 4
// bits here so wrap-around is reached.
// ---------------------------------------------------------------------------
module tb_tri_wire_sequencer;

  localparam int CW = 10;
  localparam int NW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          tri_valid;
  logic          tri_ready;
  logic [CW-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
  logic          draw_line_Start;
  logic          draw_line_Done;
  logic [CW-1:0] x0, y0, x1, y1;
  logic          busy;
  logic [NW-1:0] tri_count;

  tri_wire_sequencer #(
    .COORD_W(CW),
    .CNT_W  (NW)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .tri_valid      (tri_valid),
    .tri_ready      (tri_ready),
    .vx0            (vx0),
    .vy0            (vy0),
    .vx1            (vx1),
    .vy1            (vy1),
    .vx2            (vx2),
    .vy2            (vy2),
    .draw_line_Start(draw_line_Start),
    .draw_line_Done (draw_line_Done),
    .x0             (x0),
    .y0             (y0),
    .x1             (x1),
    .y1             (y1),
    .busy           (busy),
    .tri_count      (tri_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [CW-1:0] ax, ay, bx, by, cx, cy;
  } tri_t;

  typedef struct {
    string      name;
    tri_t       t;
    int         delay;
    int         expReq;
    int         expBusy;
    logic [39:0] e0, e1, e2;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  int            busyCount = 0;
  logic [NW-1:0] modelCount = '0;

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    if (busy === 1'b1) busyCount++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic tri_t makeTri(input int ax, input int ay, input int bx, input int by,
                                   input int cx, input int cy);
    tri_t t;
    t.ax = CW'(ax); t.ay = CW'(ay);
    t.bx = CW'(bx); t.by = CW'(by);
    t.cx = CW'(cx); t.cy = CW'(cy);
    return t;
  endfunction

  // Reference: vertex i of the triangle as {x,y}.
  function automatic logic [19:0] vertexOf(input tri_t t, input int i);
    case (i)
      0:       return {t.ax, t.ay};
      1:       return {t.bx, t.by};
      default: return {t.cx, t.cy};
    endcase
  endfunction

  // Reference: edge i runs from vertex i to the next vertex around the loop.
  function automatic logic [39:0] edgeOf(input tri_t t, input int i);
    return {vertexOf(t, i), vertexOf(t, (i + 1) % 3)};
  endfunction

  function automatic bit isDegenerate(input tri_t t);
    return (vertexOf(t, 0) == vertexOf(t, 1)) && (vertexOf(t, 1) == vertexOf(t, 2));
  endfunction

  task automatic scrambleInputs();
    vx0 = CW'($urandom_range(0, 1023));
    vy0 = CW'($urandom_range(0, 1023));
    vx1 = CW'($urandom_range(0, 1023));
    vy1 = CW'($urandom_range(0, 1023));
    vx2 = CW'($urandom_range(0, 1023));
    vy2 = CW'($urandom_range(0, 1023));
  endtask

  // Present one triangle, act as the line engine for each request and
  // check the whole transaction. Called at a falling edge.
  task automatic applyStimulus(input tri_t t, input int delay, input int expReq,
                               input int expBusy, input logic [39:0] e0,
                               input logic [39:0] e1, input logic [39:0] e2,
                               input bit scramble, input bit spurious,
                               input bit holdValid, input bit mustBeImmediate);
    logic [39:0] expEdge [3];
    int          waited;
    bit          stable;
    expEdge[0] = e0;
    expEdge[1] = e1;
    expEdge[2] = e2;

    waited = 0;
    while (tri_ready !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    checkOutput("ready_before_accept", 64'(tri_ready), 64'd1);
    if (mustBeImmediate) checkOutput("b2b_ready_wait", 64'(waited), 64'd0);

    vx0 = t.ax; vy0 = t.ay;
    vx1 = t.bx; vy1 = t.by;
    vx2 = t.cx; vy2 = t.cy;
    tri_valid = 1'b1;
    busyCount = 0;
    tick();
    if (!holdValid) tri_valid = 1'b0;
    if (scramble) scrambleInputs();

    for (int e = 0; e < expReq; e++) begin
      checkOutput($sformatf("edge%0d_start_high", e), 64'(draw_line_Start), 64'd1);
      checkOutput($sformatf("edge%0d_endpoints", e), 64'({x0, y0, x1, y1}), 64'(expEdge[e]));
      stable = 1'b1;
      tick();
      for (int k = 0; k < delay; k++) begin
        if (draw_line_Start !== 1'b1 || {x0, y0, x1, y1} !== expEdge[e]) stable = 1'b0;
        if (scramble) scrambleInputs();
        tick();
      end
      if (draw_line_Start !== 1'b1 || {x0, y0, x1, y1} !== expEdge[e]) stable = 1'b0;
      checkOutput($sformatf("edge%0d_wait_stable", e), 64'(stable), 64'd1);
      draw_line_Done = 1'b1;
      tick();
      draw_line_Done = 1'b0;
      checkOutput($sformatf("edge%0d_gap_start_low", e), 64'(draw_line_Start), 64'd0);
      checkOutput($sformatf("edge%0d_gap_endpoints", e), 64'({x0, y0, x1, y1}), 64'(expEdge[e]));
      if (spurious) draw_line_Done = 1'b1;
      tick();
      draw_line_Done = 1'b0;
    end

    checkOutput("finish_start_low", 64'(draw_line_Start), 64'd0);
    checkOutput("finish_busy", 64'(busy), 64'd1);
    waited = 0;
    while (tri_ready !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    checkOutput("ready_returned", 64'(tri_ready), 64'd1);
    modelCount = modelCount + NW'(1);
    checkOutput("busy_cycles", 64'(busyCount), 64'(expBusy));
    checkOutput("tri_count", 64'(tri_count), 64'(modelCount));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_start"}, 64'(draw_line_Start), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_ready"}, 64'(tri_ready), 64'd1);
    checkOutput({tag, "_count"}, 64'(tri_count), 64'd0);
    checkOutput({tag, "_endpoints"}, 64'({x0, y0, x1, y1}), 64'd0);
  endtask

  vec_t vecs [5];

  initial begin
    tri_t rt;
    int   rd;
    tri_t tA;

    vecs[0] = '{"basic_d3", makeTri(10, 30, 40, 20, 25, 5), 3, 3, 19,
                {10'd10, 10'd30, 10'd40, 10'd20}, {10'd40, 10'd20, 10'd25, 10'd5},
                {10'd25, 10'd5, 10'd10, 10'd30}};
    vecs[1] = '{"degenerate", makeTri(7, 7, 7, 7, 7, 7), 0, 0, 1,
                40'd0, 40'd0, 40'd0};
    vecs[2] = '{"immediate_done", makeTri(1, 2, 3, 4, 5, 6), 0, 3, 10,
                {10'd1, 10'd2, 10'd3, 10'd4}, {10'd3, 10'd4, 10'd5, 10'd6},
                {10'd5, 10'd6, 10'd1, 10'd2}};
    vecs[3] = '{"long_done", makeTri(0, 0, 1023, 0, 0, 1023), 50, 3, 160,
                {10'd0, 10'd0, 10'd1023, 10'd0}, {10'd1023, 10'd0, 10'd0, 10'd1023},
                {10'd0, 10'd1023, 10'd0, 10'd0}};
    vecs[4] = '{"repeated_vertex", makeTri(100, 100, 100, 100, 200, 50), 1, 3, 13,
                {10'd100, 10'd100, 10'd100, 10'd100}, {10'd100, 10'd100, 10'd200, 10'd50},
                {10'd200, 10'd50, 10'd100, 10'd100}};

    Reset = 1'b1;
    tri_valid = 1'b0;
    draw_line_Done = 1'b0;
    vx0 = '0; vy0 = '0; vx1 = '0; vy1 = '0; vx2 = '0; vy2 = '0;
    @(negedge Clk);
    tick();
    tick();
    Reset = 1'b0;
    checkResetState("reset");

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %s", vecs[i].name);
      applyStimulus(vecs[i].t, vecs[i].delay, vecs[i].expReq, vecs[i].expBusy,
                    vecs[i].e0, vecs[i].e1, vecs[i].e2, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset while edge 1 is waiting, together with Done and tri_valid.
    $display("[TB] reset during edge 1");
    tA = makeTri(10, 30, 40, 20, 25, 5);
    vx0 = tA.ax; vy0 = tA.ay; vx1 = tA.bx; vy1 = tA.by; vx2 = tA.cx; vy2 = tA.cy;
    tri_valid = 1'b1;
    tick();
    tri_valid = 1'b0;
    tick();
    draw_line_Done = 1'b1;
    tick();
    draw_line_Done = 1'b0;
    tick();
    checkOutput("abort_edge1_endpoints", 64'({x0, y0, x1, y1}), 64'(edgeOf(tA, 1)));
    tick();
    tick();
    Reset = 1'b1;
    draw_line_Done = 1'b1;
    tri_valid = 1'b1;
    tick();
    Reset = 1'b0;
    draw_line_Done = 1'b0;
    tri_valid = 1'b0;
    checkResetState("abort");
    modelCount = '0;
    tick();
    checkOutput("abort_stays_idle", 64'(busy), 64'd0);
    applyStimulus(tA, 2, 3, 3 * (2 + 3) + 1, edgeOf(tA, 0), edgeOf(tA, 1), edgeOf(tA, 2),
                  1'b0, 1'b0, 1'b0, 1'b0);

    // Inputs scrambled while busy, spurious Done in every gap.
    $display("[TB] scrambled inputs and spurious done");
    applyStimulus(tA, 2, 3, 3 * (2 + 3) + 1, edgeOf(tA, 0), edgeOf(tA, 1), edgeOf(tA, 2),
                  1'b1, 1'b1, 1'b0, 1'b0);

    // Back-to-back triangles with tri_valid held high.
    $display("[TB] back-to-back");
    rt = makeTri(300, 400, 500, 600, 700, 800);
    applyStimulus(tA, 1, 3, 3 * (2 + 2) + 1, edgeOf(tA, 0), edgeOf(tA, 1), edgeOf(tA, 2),
                  1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(rt, 0, 3, 3 * (2 + 1) + 1, edgeOf(rt, 0), edgeOf(rt, 1), edgeOf(rt, 2),
                  1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized triangles against the reference.
    $display("[TB] random triangles");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rt.ax = CW'($urandom_range(0, 1023));
        rt.ay = CW'($urandom_range(0, 1023));
        rt.bx = rt.ax; rt.by = rt.ay; rt.cx = rt.ax; rt.cy = rt.ay;
      end else if ($urandom_range(0, 2) == 0) begin
        rt.ax = CW'($urandom_range(0, 2)); rt.ay = CW'($urandom_range(0, 2));
        rt.bx = CW'($urandom_range(0, 2)); rt.by = CW'($urandom_range(0, 2));
        rt.cx = CW'($urandom_range(0, 2)); rt.cy = CW'($urandom_range(0, 2));
      end else begin
        rt.ax = CW'($urandom_range(0, 1023)); rt.ay = CW'($urandom_range(0, 1023));
        rt.bx = CW'($urandom_range(0, 1023)); rt.by = CW'($urandom_range(0, 1023));
        rt.cx = CW'($urandom_range(0, 1023)); rt.cy = CW'($urandom_range(0, 1023));
      end
      rd = $urandom_range(0, 6);
      if (isDegenerate(rt)) begin
        applyStimulus(rt, rd, 0, 1, 40'd0, 40'd0, 40'd0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end else begin
        applyStimulus(rt, rd, 3, 3 * (2 + (rd + 1)) + 1,
                      edgeOf(rt, 0), edgeOf(rt, 1), edgeOf(rt, 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
